// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row-scan sequencer, debouncer and key-code FIFO for a 5x4 key matrix.
// Ports: clk, rst (sync, active-high), scan_en, k_col[3:0] (active-low sense lines),
//        k_row[4:0] (active-low drive), key_code[4:0], key_valid, key_rd,
//        key_down, multi_key, fifo_ovf (sticky).
module keypad_scan_ctrl #(
    parameter int ROWS         = 5,
    parameter int COLS         = 4,
    parameter int SETTLE_CYC   = 1000,
    parameter int STABLE_SCANS = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic [3:0] k_col,
    output logic [4:0] k_row,
    output logic [4:0] key_code,
    output logic       key_valid,
    input  logic       key_rd,
    output logic       key_down,
    output logic       multi_key,
    output logic       fifo_ovf
);

    localparam int NK  = ROWS * COLS;
    localparam int SW  = $clog2(SETTLE_CYC + 1);
    localparam int STW = $clog2(STABLE_SCANS + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        EVAL
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      row_q, row_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [STW-1:0]  stable_q, stable_d;
    logic [NK-1:0]   img_q, img_d;
    logic [NK-1:0]   last_q, last_d;
    logic [NK-1:0]   acc_q, acc_d;
    logic [4:0]      k_row_q, k_row_d;
    logic            down_q, multi_q;

    logic            accept;
    logic            push;
    logic [4:0]      img_ones;
    logic [4:0]      push_code;

    logic [4:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;
    logic            empty, full, pop, wr;

    // Key count of the scanned image; the code is the bit index, which is
    // only used when exactly one bit is set.
    always_comb begin
        img_ones  = '0;
        push_code = '0;
        for (int i = 0; i < NK; i++) begin
            if (img_q[i]) begin
                img_ones  = img_ones + 5'd1;
                push_code = 5'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        stable_d = stable_q;
        img_d    = img_q;
        last_d   = last_q;
        acc_d    = acc_q;
        accept   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (scan_en) begin
                    state_d  = DRIVE;
                    row_d    = '0;
                    settle_d = '0;
                end
            end
            DRIVE: begin
                if (!scan_en) begin
                    state_d  = IDLE;
                    row_d    = '0;
                    settle_d = '0;
                end else if (settle_q == SW'(SETTLE_CYC - 1)) begin
                    state_d  = SAMPLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (!scan_en) begin
                    state_d = IDLE;
                    row_d   = '0;
                end else begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (row_q == 3'(r)) begin
                            img_d[r*COLS +: COLS] = ~k_col;
                        end
                    end
                    if (row_q == 3'(ROWS - 1)) begin
                        state_d = EVAL;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = DRIVE;
                    end
                end
            end
            EVAL: begin
                if (img_q != last_q) begin
                    last_d   = img_q;
                    stable_d = '0;
                end else if (stable_q != STW'(STABLE_SCANS)) begin
                    stable_d = stable_q + 1'b1;
                    // Only the step into saturation accepts.
                    accept   = (stable_q == STW'(STABLE_SCANS - 1));
                end
                if (accept) begin
                    acc_d = img_q;
                end
                state_d  = scan_en ? DRIVE : IDLE;
                row_d    = '0;
                settle_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign push = accept && (img_ones == 5'd1) && ((img_q & ~acc_q) != '0);

    // Row drive follows the next state so k_row is valid in the same cycle
    // the FSM enters DRIVE, and stays asserted through SAMPLE.
    always_comb begin
        k_row_d = 5'b11111;
        if (state_d == DRIVE || state_d == SAMPLE) begin
            k_row_d = ~(5'b00001 << row_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            settle_q <= '0;
            stable_q <= '0;
            img_q    <= '0;
            last_q   <= '0;
            acc_q    <= '0;
            k_row_q  <= 5'b11111;
            down_q   <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            stable_q <= stable_d;
            img_q    <= img_d;
            last_q   <= last_d;
            acc_q    <= acc_d;
            k_row_q  <= k_row_d;
            if (accept) begin
                down_q  <= (img_q != '0);
                multi_q <= (img_ones > 5'd1);
            end
        end
    end

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign pop   = key_rd && !empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign wr    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wp_q] <= push_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr) begin
                wp_q <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end
            if (push && !wr) begin
                ovf_q <= 1'b1;
            end
            if (wr && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!wr && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign k_row     = k_row_q;
    assign key_valid = !empty;
    assign key_code  = empty ? 5'd0 : mem_q[rp_q];
    assign key_down  = down_q;
    assign multi_key = multi_q;
    assign fifo_ovf  = ovf_q;

endmodule
